mc_delay_line: RTL and testbench

//  Parametrised multi-channel tapped delay line for the 4-channel delay path.
//  - Each channel has a DEPTH-stage shift register of DW-bit samples, all advancing on a shared sample strobe.
//  - Each channel has a run-time programmable tap select, so one registered output per channel carries that channel's delayed sample.
//  - Adds fill tracking (output valid), a synchronous flush and out-of-range delay clamping.

---
 rtl/mc_delay_line_if.sv | 19 +
 rtl/mc_delay_line.sv | 60 ++++++
 tb/tb_mc_delay_line.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mc_delay_line_if.sv
// mc_delay_line_if: sample strobe, config and delayed-output bundle for mc_delay_line.
interface mc_delay_line_if #(
  parameter int NCH  = 4,
  parameter int DW   = 14,
  parameter int TAPW = 6
);
  logic                 shift_en;
  logic [NCH*DW-1:0]    in_data;
  logic                 flush;
  logic                 cfg_load;
  logic [NCH*TAPW-1:0]  cfg_delay;
  logic [NCH*DW-1:0]    out_data;
  logic [NCH-1:0]       out_valid;
  logic                 cfg_err;
  modport master (output shift_en, in_data, flush, cfg_load, cfg_delay,
                  input  out_data, out_valid, cfg_err);
  modport slave  (input  shift_en, in_data, flush, cfg_load, cfg_delay,
                  output out_data, out_valid, cfg_err);
endinterface

// File: rtl/mc_delay_line.sv
// mc_delay_line: multi-channel tapped delay line with per-channel programmable tap, fill tracking and flush.
module mc_delay_line #(
  parameter int NCH   = 4,
  parameter int DW    = 14,
  parameter int DEPTH = 43,
  parameter int TAPW  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  mc_delay_line_if.slave  bus
);
  localparam int FW = $clog2(DEPTH + 1);
  localparam logic [TAPW-1:0] MAXD = TAPW'(DEPTH - 1);
  localparam logic [FW-1:0]   FULL = FW'(DEPTH);
  logic [DW-1:0]       tap_q [NCH][DEPTH];
  logic [TAPW-1:0]     delay_q [NCH];
  logic [TAPW-1:0]     delay_d [NCH];
  logic [NCH-1:0]      bad;
  logic [FW-1:0]       fill_q;
  logic [NCH*DW-1:0]   out_data_q;
  logic [NCH-1:0]      out_valid_q;
  logic                cfg_err_q;
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      bad[c]     = bus.cfg_delay[c*TAPW +: TAPW] > MAXD;
      delay_d[c] = bad[c] ? MAXD : bus.cfg_delay[c*TAPW +: TAPW];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        for (int k = 0; k < DEPTH; k++) tap_q[c][k] <= '0;
        delay_q[c] <= '0;
      end
      fill_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (bus.flush) begin
          for (int k = 0; k < DEPTH; k++) tap_q[c][k] <= '0;
        end else if (bus.shift_en) begin
          tap_q[c][0] <= bus.in_data[c*DW +: DW];
          for (int k = 1; k < DEPTH; k++) tap_q[c][k] <= tap_q[c][k-1];
        end
        if (bus.cfg_load) delay_q[c] <= delay_d[c];
        // Output reads pre-edge taps and delay, giving the fixed 1-clk output lag
        out_data_q[c*DW +: DW] <= tap_q[c][delay_q[c]];
        out_valid_q[c]         <= fill_q > FW'(delay_q[c]);
      end
      if (bus.flush) fill_q <= '0;
      else if (bus.shift_en && fill_q != FULL) fill_q <= fill_q + 1'b1;
      if (bus.cfg_load && |bad) cfg_err_q <= 1'b1;
    end
  end
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_mc_delay_line.sv
// tb_mc_delay_line: randomized scoreboard bench; the reference keeps per-channel sample history queues.
module tb_mc_delay_line;
  localparam int NCH = 4, DW = 14, DEPTH = 43, TAPW = $clog2(DEPTH);
  typedef struct packed {
    logic [NCH*DW-1:0] d;
    logic [NCH-1:0]    v;
    logic              e;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  mc_delay_line_if #(.NCH(NCH), .DW(DW), .TAPW(TAPW)) bus();
  mc_delay_line #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH), .TAPW(TAPW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  exp_t exp_q[$];
  int   hist[NCH][$];
  int   mdel[NCH];
  bit   merr;
  int   checks = 0, errors = 0;
  function automatic int tapv(int c, int k);
    return (k < hist[c].size()) ? hist[c][hist[c].size()-1-k] : 0;
  endfunction
  task automatic check(string name, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, want, $time);
    end
  endtask
  function automatic logic [NCH*DW-1:0] rnd_data();
    logic [NCH*DW-1:0] d;
    for (int c = 0; c < NCH; c++) d[c*DW +: DW] = DW'($urandom);
    return d;
  endfunction
  function automatic logic [NCH*TAPW-1:0] rnd_cd(int mx);
    logic [NCH*TAPW-1:0] v;
    for (int c = 0; c < NCH; c++) v[c*TAPW +: TAPW] = TAPW'($urandom_range(0, mx));
    return v;
  endfunction
  // Drive one cycle of inputs, push the expected post-edge outputs, then advance the model
  task automatic step(bit r, bit s, bit f, bit l, logic [NCH*DW-1:0] d, logic [NCH*TAPW-1:0] cd);
    exp_t x;
    bit anybad;
    int code;
    @(negedge clk);
    rst = r; bus.shift_en = s; bus.flush = f; bus.cfg_load = l; bus.in_data = d; bus.cfg_delay = cd;
    anybad = 0;
    for (int c = 0; c < NCH; c++) if (int'(cd[c*TAPW +: TAPW]) >= DEPTH) anybad = 1;
    x = '0;
    if (!r) begin
      for (int c = 0; c < NCH; c++) begin
        x.d[c*DW +: DW] = DW'(tapv(c, mdel[c]));
        x.v[c] = hist[c].size() > mdel[c];
      end
      x.e = merr | (l & anybad);
    end
    exp_q.push_back(x);
    if (r) begin
      for (int c = 0; c < NCH; c++) begin
        hist[c].delete();
        mdel[c] = 0;
      end
      merr = 0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (f) hist[c].delete();
        else if (s) begin
          hist[c].push_back(int'(d[c*DW +: DW]));
          if (hist[c].size() > DEPTH) void'(hist[c].pop_front());
        end
        code = int'(cd[c*TAPW +: TAPW]);
        if (l) mdel[c] = (code >= DEPTH) ? DEPTH - 1 : code;
      end
      merr = x.e;
    end
  endtask
  initial forever begin
    exp_t x;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      check("out_data", 64'(bus.out_data), 64'(x.d));
      check("out_valid", 64'(bus.out_valid), 64'(x.v));
      check("cfg_err", 64'(bus.cfg_err), 64'(x.e));
    end
  end
  initial begin
    logic [NCH*DW-1:0] d;
    logic [NCH*TAPW-1:0] cd;
    bus.shift_en = 0; bus.flush = 0; bus.cfg_load = 0; bus.in_data = '0; bus.cfg_delay = '0;
    // 1: delay 0, single strobe
    step(1, 0, 0, 0, '0, '0);
    step(0, 0, 0, 1, '0, '0);
    d = rnd_data();
    d[DW-1:0] = 14'h0123;
    step(0, 1, 0, 0, d, '0);
    step(0, 0, 0, 0, '0, '0);
    @(posedge clk); #2;
    check("t1_ch0", 64'(bus.out_data[DW-1:0]), 64'h0123);
    check("t1_valid", 64'(bus.out_valid), 64'hF);
    // 2: delays {3,7,0,42}, ramp
    step(0, 0, 1, 1, '0, {6'd42, 6'd0, 6'd7, 6'd3});
    for (int k = 1; k <= 60; k++) step(0, 1, 0, 0, {4{14'(k)}}, '0);
    step(0, 0, 0, 0, '0, '0);
    @(posedge clk); #2;
    check("t2_ch0", 64'(bus.out_data[0*DW +: DW]), 64'd57);
    check("t2_ch1", 64'(bus.out_data[1*DW +: DW]), 64'd53);
    check("t2_ch2", 64'(bus.out_data[2*DW +: DW]), 64'd60);
    check("t2_ch3", 64'(bus.out_data[3*DW +: DW]), 64'd18);
    // 3: gapped strobes, delay 2
    step(0, 0, 0, 1, '0, {4{6'd2}});
    for (int i = 0; i < 30; i++) step(0, (i % 3) == 0, 0, 0, rnd_data(), '0);
    // 4: out-of-range code clamps and sets sticky error
    step(0, 1, 0, 1, rnd_data(), {6'd5, 6'd50, 6'd1, 6'd4});
    @(posedge clk); #2;
    check("t4_err", 64'(bus.cfg_err), 64'd1);
    for (int i = 0; i < 50; i++) step(0, 1, 0, 0, rnd_data(), '0);
    step(0, 1, 0, 1, rnd_data(), {6'd30, 6'd20, 6'd10, 6'd5});
    @(posedge clk); #2;
    check("t4_sticky", 64'(bus.cfg_err), 64'd1);
    // 5: flush with shift after 45 strobes
    for (int i = 0; i < 45; i++) step(0, 1, 0, 0, rnd_data(), '0);
    step(0, 1, 1, 0, rnd_data(), '0);
    step(0, 0, 0, 0, '0, '0);
    @(posedge clk); #2;
    check("t5_data", 64'(bus.out_data), 64'd0);
    check("t5_valid", 64'(bus.out_valid), 64'd0);
    for (int i = 0; i < 35; i++) step(0, 1, 0, 0, rnd_data(), '0);
    // 6: mid-stream reset
    step(1, 1, 0, 0, rnd_data(), '0);
    @(posedge clk); #2;
    check("t6_data", 64'(bus.out_data), 64'd0);
    check("t6_valid", 64'(bus.out_valid), 64'd0);
    check("t6_err", 64'(bus.cfg_err), 64'd0);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, rnd_data(), '0);
    // random mix
    for (int i = 0; i < 500; i++) begin
      cd = rnd_cd(63);
      step($urandom_range(0, 149) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 11) == 0, rnd_data(), cd);
    end
    step(0, 0, 0, 0, '0, '0);
    repeat (3) @(posedge clk);
    #3;
    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
